slot_ring_ctrl: RTL and testbench
=================================

Name: slot_ring_ctrl

Overview:
Controller for the 4-slot frame buffer ring, which has one writer and two independent readers (reader 1, reader 0). It owns the 3-bit write and read slot pointers (bit 2 = lap, bits 1:0 = slot index) and derives the full/empty flags from them. It admits or discards each incoming frame at start-of-frame and commits it on end-of-frame. It stores a per-slot frame length for the readers. It sits between the ingress frame parser, the slot buffer RAM addressing, and the two egress readers.

Parameters:
LEN_W, 11, width of the stored frame length in bytes.
CNT_W, 16, width of the saturating drop counter.

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
sof_in  in  1  start-of-frame pulse from ingress
eof_in  in  1  end-of-frame pulse from ingress
len_in  in  LEN_W  frame length; valid with eof_in
err_in  in  1  frame error; valid with eof_in
wr_en_out  out  1  ingress may write frame data into slot wr_ptr_tribit[1:0]
wr_ptr_tribit  out  3  write slot pointer
rd_ptr_tribit_1  out  3  reader 1 slot pointer
rd_ptr_tribit_0  out  3  reader 0 slot pointer
rd_done_1  in  1  reader 1 has finished its current slot
rd_done_0  in  1  reader 0 has finished its current slot
wr_greenflag  out  1  not_full
rd_greenflag_1  out  1  reader 1 not_empty
rd_greenflag_0  out  1  reader 0 not_empty
rd_len_1  out  LEN_W  stored length of slot rd_ptr_tribit_1[1:0]
rd_len_0  out  LEN_W  stored length of slot rd_ptr_tribit_0[1:0]
drop_cnt  out  CNT_W  count of discarded or aborted frames; saturates at all-ones

Behaviour:
- Reset (asynchronous): all pointers 3'b000; FSM state IDLE; length memory cleared to 0; drop_cnt 0. Resulting outputs: wr_greenflag 1, rd_greenflag_1/0 0, wr_en_out 0.
- Flags are combinational from the registered pointers:
  - wr_greenflag = 0 when, for either reader, wr[2] != rd[2] and wr[1:0] == rd[1:0].
  - rd_greenflag_x = 0 when wr_ptr == rd_ptr_x.
- Pointers increment modulo 8, so bit 2 toggles on each wrap.
- Write FSM states:
  - IDLE: on sof_in, if wr_greenflag=1 go to ACCEPT, otherwise go to DISCARD and increment drop_cnt.
  - ACCEPT: on eof_in, go to IDLE.
    - If err_in=0: write len_in into len_mem[wr_ptr[1:0]] and increment wr_ptr.
    - If err_in=1: no commit, wr_ptr unchanged; increment drop_cnt.
  - DISCARD: on eof_in, go to IDLE with no commit.
- wr_en_out is combinational: 1 when state is ACCEPT, or when state is IDLE with sof_in=1 and wr_greenflag=1. This lets the first data beat land in the sof cycle.
- sof_in and eof_in in the same cycle in IDLE is a single-cycle frame. It is admitted and committed (or dropped) in that cycle, and the state remains IDLE.
- sof_in in ACCEPT or DISCARD is ignored. eof_in in IDLE without sof_in is ignored.
- Admission is decided only at sof. The admitted slot stays reserved because only commit advances wr_ptr; reads freeing space mid-frame have no effect on the current frame.
- Readers: rd_done_x with rd_greenflag_x=1 increments rd_ptr_x at the next edge. rd_done_x with rd_greenflag_x=0 is ignored.
- rd_len_x is a combinational read of len_mem at rd_ptr_x[1:0].
- Simultaneous commit and rd_done (either or both readers) all update in the same edge. Flags reflect the new pointers in the following cycle.
- rst asserted mid-frame: the in-flight frame is lost and not counted. Data or eof arriving after rst deasserts without a new sof is ignored.

Test Plan:
1. Apply and release rst -> all pointers 000, wr_greenflag=1, rd_greenflag_1=0, rd_greenflag_0=0, drop_cnt=0, wr_en_out=0.
2. Commit 4 frames (len 64, 128, 256, 1518) with no reads -> wr_ptr=100, wr_greenflag=0, both rd_greenflags=1, rd_len_1=rd_len_0=64.
3. 5th frame while full -> FSM enters DISCARD, wr_en_out stays 0, drop_cnt=1, wr_ptr stays 100; the following eof returns the FSM to IDLE.
4. From full, pulse rd_done_1 four times -> rd_ptr_1=100, rd_greenflag_1=0, wr_greenflag stays 0 (reader 0 still holds). One rd_done_0 -> wr_greenflag=1. A 5th rd_done_1 -> ignored, rd_ptr_1 stays 100.
5. Frame with err_in=1 at eof -> wr_ptr unchanged, drop_cnt increments, len_mem unchanged. A single-cycle sof+eof frame with len 60 -> committed in one cycle, wr_ptr increments.
6. Nine frames interleaved with reads from both readers, including commit and both rd_done in the same cycle -> pointers wrap to 001, flags correct every cycle, rd_len tracks per slot. Assert rst mid-frame -> full reset state, and a stray eof afterwards is ignored.

Source files
------------

// File: rtl/slot_ring_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : slot_ring_ctrl_if
// Brief    : Ingress / egress signal bundle for the 4-slot frame ring
//            controller. The slave side is the controller itself; the master
//            side is the ingress parser plus the two egress readers.
// Revision : 1.0 - initial release
// ============================================================================
interface slot_ring_ctrl_if #(
  parameter int LEN_W = 11,
  parameter int CNT_W = 16
);
  // Ingress frame framing
  logic             sof_in;
  logic             eof_in;
  logic [LEN_W-1:0] len_in;
  logic             err_in;
  logic             wr_en_out;
  logic [2:0]       wr_ptr_tribit;
  logic             wr_greenflag;
  // Egress readers
  logic [2:0]       rd_ptr_tribit_1;
  logic [2:0]       rd_ptr_tribit_0;
  logic             rd_done_1;
  logic             rd_done_0;
  logic             rd_greenflag_1;
  logic             rd_greenflag_0;
  logic [LEN_W-1:0] rd_len_1;
  logic [LEN_W-1:0] rd_len_0;
  // Statistics
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    output sof_in, eof_in, len_in, err_in, rd_done_1, rd_done_0,
    input  wr_en_out, wr_ptr_tribit, wr_greenflag,
    input  rd_ptr_tribit_1, rd_ptr_tribit_0, rd_greenflag_1, rd_greenflag_0,
    input  rd_len_1, rd_len_0, drop_cnt
  );

  modport slave (
    input  sof_in, eof_in, len_in, err_in, rd_done_1, rd_done_0,
    output wr_en_out, wr_ptr_tribit, wr_greenflag,
    output rd_ptr_tribit_1, rd_ptr_tribit_0, rd_greenflag_1, rd_greenflag_0,
    output rd_len_1, rd_len_0, drop_cnt
  );
endinterface
`default_nettype wire

// File: rtl/slot_ring_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : slot_ring_ctrl
// Brief    : Pointer/flag controller for a 4-slot frame ring with one writer
//            and two independent readers. Admits frames at sof, commits them
//            (pointer advance + stored length) at eof, counts drops.
// Revision : 1.0 - initial release
// ============================================================================
module slot_ring_ctrl #(
  parameter int LEN_W = 11,
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             rst,
  slot_ring_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCEPT  = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_wr_ptr;
  logic [2:0]       r_rd_ptr_1;
  logic [2:0]       r_rd_ptr_0;
  logic [LEN_W-1:0] r_len_mem [4];
  logic [CNT_W-1:0] r_drop_cnt;

  logic w_full;
  logic w_rd_avail_1;
  logic w_rd_avail_0;
  logic w_commit;
  logic w_drop;
  logic w_wr_en;

  // Full when the writer is exactly one lap ahead of the slower reader.
  assign w_full = ((r_wr_ptr[2] != r_rd_ptr_1[2]) && (r_wr_ptr[1:0] == r_rd_ptr_1[1:0])) ||
                  ((r_wr_ptr[2] != r_rd_ptr_0[2]) && (r_wr_ptr[1:0] == r_rd_ptr_0[1:0]));
  assign w_rd_avail_1 = (r_wr_ptr != r_rd_ptr_1);
  assign w_rd_avail_0 = (r_wr_ptr != r_rd_ptr_0);

  // Write FSM: admission at sof, commit/drop decision at eof.
  // A sof+eof pair in IDLE is a complete frame and is resolved in that cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    w_drop      = 1'b0;
    w_wr_en     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.sof_in) begin
          if (!w_full) begin
            w_wr_en = 1'b1;
            if (bus.eof_in) begin
              if (bus.err_in) w_drop = 1'b1;
              else            w_commit = 1'b1;
            end else begin
              w_state_nxt = S_ACCEPT;
            end
          end else begin
            w_drop = 1'b1;
            if (!bus.eof_in) w_state_nxt = S_DISCARD;
          end
        end
      end
      S_ACCEPT: begin
        w_wr_en = 1'b1;
        if (bus.eof_in) begin
          w_state_nxt = S_IDLE;
          if (bus.err_in) w_drop = 1'b1;
          else            w_commit = 1'b1;
        end
      end
      S_DISCARD: begin
        if (bus.eof_in) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Write pointer and per-slot length store; only a commit advances the
  // pointer, so an admitted slot stays reserved for the whole frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 3'b000;
      for (int i = 0; i < 4; i++) r_len_mem[i] <= '0;
    end else if (w_commit) begin
      r_wr_ptr                <= r_wr_ptr + 3'd1;
      r_len_mem[r_wr_ptr[1:0]] <= bus.len_in;
    end
  end

  // Saturating drop counter (refused at sof or errored at eof).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            r_drop_cnt <= '0;
    else if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
  end

  // Reader pointers advance only when their reader has a slot to release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr_1 <= 3'b000;
      r_rd_ptr_0 <= 3'b000;
    end else begin
      if (bus.rd_done_1 && w_rd_avail_1) r_rd_ptr_1 <= r_rd_ptr_1 + 3'd1;
      if (bus.rd_done_0 && w_rd_avail_0) r_rd_ptr_0 <= r_rd_ptr_0 + 3'd1;
    end
  end

  assign bus.wr_en_out       = w_wr_en;
  assign bus.wr_ptr_tribit   = r_wr_ptr;
  assign bus.wr_greenflag    = ~w_full;
  assign bus.rd_ptr_tribit_1 = r_rd_ptr_1;
  assign bus.rd_ptr_tribit_0 = r_rd_ptr_0;
  assign bus.rd_greenflag_1  = w_rd_avail_1;
  assign bus.rd_greenflag_0  = w_rd_avail_0;
  assign bus.rd_len_1        = r_len_mem[r_rd_ptr_1[1:0]];
  assign bus.rd_len_0        = r_len_mem[r_rd_ptr_0[1:0]];
  assign bus.drop_cnt        = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_slot_ring_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_slot_ring_ctrl
// Brief    : Self-checking bench for slot_ring_ctrl: directed vector table,
//            randomized traffic against a frame-count reference model,
//            mid-frame reset and a nine-frame wrap sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_slot_ring_ctrl;

  localparam int LEN_W = 11;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  slot_ring_ctrl_if #(.LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

  slot_ring_ctrl #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: counts of frames committed / consumed per reader plus the
  // history of every committed length. Slot contents follow from frame numbers.
  int m_w, m_r1, m_r0, m_drop;
  int hist[$];
  bit m_in_frame, m_admitted;
  logic last_en;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_w = 0; m_r1 = 0; m_r0 = 0; m_drop = 0;
    hist.delete();
    m_in_frame = 0; m_admitted = 0;
  endfunction

  function automatic bit m_full();
    int lo;
    lo = (m_r1 < m_r0) ? m_r1 : m_r0;
    return (m_w - lo) == 4;
  endfunction

  // Slot r%4 holds the newest committed frame n < W with n == r (mod 4).
  function automatic int m_len(input int r);
    if (r < m_w)  return hist[r];
    if (r >= 4)   return hist[r - 4];
    return 0;
  endfunction

  function automatic void model_edge(input logic sof, eof, err, d1, d0, input int len);
    bit full, commit, drop;
    full = m_full(); commit = 0; drop = 0;
    if (!m_in_frame) begin
      if (sof) begin
        if (!full) begin
          if (eof) begin if (err) drop = 1; else commit = 1; end
          else begin m_in_frame = 1; m_admitted = 1; end
        end else begin
          drop = 1;
          if (!eof) begin m_in_frame = 1; m_admitted = 0; end
        end
      end
    end else if (eof) begin
      m_in_frame = 0;
      if (m_admitted) begin if (err) drop = 1; else commit = 1; end
    end
    if (d1 && m_r1 < m_w) m_r1++;
    if (d0 && m_r0 < m_w) m_r0++;
    if (commit) begin hist.push_back(len); m_w++; end
    if (drop && m_drop < 65535) m_drop++;
  endfunction

  task automatic check_model();
    chk("wr_en_out", int'(bus.wr_en_out),
        int'((m_in_frame && m_admitted) || (!m_in_frame && bus.sof_in && !m_full())));
    chk("wr_ptr", int'(bus.wr_ptr_tribit), m_w % 8);
    chk("rd_ptr_1", int'(bus.rd_ptr_tribit_1), m_r1 % 8);
    chk("rd_ptr_0", int'(bus.rd_ptr_tribit_0), m_r0 % 8);
    chk("wr_greenflag", int'(bus.wr_greenflag), int'(!m_full()));
    chk("rd_greenflag_1", int'(bus.rd_greenflag_1), int'(m_r1 != m_w));
    chk("rd_greenflag_0", int'(bus.rd_greenflag_0), int'(m_r0 != m_w));
    chk("rd_len_1", int'(bus.rd_len_1), m_len(m_r1));
    chk("rd_len_0", int'(bus.rd_len_0), m_len(m_r0));
    chk("drop_cnt", int'(bus.drop_cnt), m_drop);
  endtask

  // One clock of stimulus: drive at negedge, check pre-edge outputs, advance
  // the model at the edge, return 1 time unit after the edge.
  task automatic step(input logic sof, eof, err, d1, d0, input int len);
    @(negedge clk);
    bus.sof_in = sof; bus.eof_in = eof; bus.err_in = err;
    bus.rd_done_1 = d1; bus.rd_done_0 = d0;
    bus.len_in = LEN_W'(len);
    #1;
    check_model();
    last_en = bus.wr_en_out;
    @(posedge clk);
    model_edge(sof, eof, err, d1, d0, len);
    #1;
  endtask

  task automatic idle_inputs();
    bus.sof_in = 0; bus.eof_in = 0; bus.err_in = 0;
    bus.rd_done_1 = 0; bus.rd_done_0 = 0; bus.len_in = '0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " wr_ptr"}, int'(bus.wr_ptr_tribit), 0);
    chk({tag, " rd_ptr_1"}, int'(bus.rd_ptr_tribit_1), 0);
    chk({tag, " rd_ptr_0"}, int'(bus.rd_ptr_tribit_0), 0);
    chk({tag, " wr_greenflag"}, int'(bus.wr_greenflag), 1);
    chk({tag, " rd_greenflag_1"}, int'(bus.rd_greenflag_1), 0);
    chk({tag, " rd_greenflag_0"}, int'(bus.rd_greenflag_0), 0);
    chk({tag, " drop_cnt"}, int'(bus.drop_cnt), 0);
    chk({tag, " wr_en_out"}, int'(bus.wr_en_out), 0);
  endtask

  typedef struct {
    logic sof, eof, err, d1, d0;
    int   len;
    logic exp_en;
    int   wr, r1, r0;
    logic wgf, g1, g0;
    int   drop, l1, l0;
  } vec_t;

  function automatic vec_t v(input logic sof, eof, err, d1, d0, input int len,
                             input logic en, input int wr, r1, r0,
                             input logic wgf, g1, g0, input int drop, l1, l0);
    vec_t t;
    t.sof = sof; t.eof = eof; t.err = err; t.d1 = d1; t.d0 = d0; t.len = len;
    t.exp_en = en; t.wr = wr; t.r1 = r1; t.r0 = r0;
    t.wgf = wgf; t.g1 = g1; t.g0 = g0; t.drop = drop; t.l1 = l1; t.l0 = l0;
    return t;
  endfunction

  vec_t tbl[21];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Inputs: sof eof err d1 d0 len | wr_en during cycle | post-edge state
    tbl[0]  = v(1,0,0,0,0,0,    1, 0,0,0, 1,0,0, 0,0,0);
    tbl[1]  = v(0,1,0,0,0,64,   1, 1,0,0, 1,1,1, 0,64,64);
    tbl[2]  = v(1,0,0,0,0,0,    1, 1,0,0, 1,1,1, 0,64,64);
    tbl[3]  = v(0,1,0,0,0,128,  1, 2,0,0, 1,1,1, 0,64,64);
    tbl[4]  = v(1,1,0,0,0,256,  1, 3,0,0, 1,1,1, 0,64,64);
    tbl[5]  = v(1,0,0,0,0,0,    1, 3,0,0, 1,1,1, 0,64,64);
    tbl[6]  = v(1,0,0,0,0,0,    1, 3,0,0, 1,1,1, 0,64,64);
    tbl[7]  = v(0,1,0,0,0,1518, 1, 4,0,0, 0,1,1, 0,64,64);
    tbl[8]  = v(1,0,0,0,0,0,    0, 4,0,0, 0,1,1, 1,64,64);
    tbl[9]  = v(0,0,0,0,0,0,    0, 4,0,0, 0,1,1, 1,64,64);
    tbl[10] = v(0,1,0,0,0,99,   0, 4,0,0, 0,1,1, 1,64,64);
    tbl[11] = v(0,0,0,1,0,0,    0, 4,1,0, 0,1,1, 1,128,64);
    tbl[12] = v(0,0,0,1,0,0,    0, 4,2,0, 0,1,1, 1,256,64);
    tbl[13] = v(0,0,0,1,0,0,    0, 4,3,0, 0,1,1, 1,1518,64);
    tbl[14] = v(0,0,0,1,0,0,    0, 4,4,0, 0,0,1, 1,64,64);
    tbl[15] = v(0,0,0,0,1,0,    0, 4,4,1, 1,0,1, 1,64,128);
    tbl[16] = v(0,0,0,1,0,0,    0, 4,4,1, 1,0,1, 1,64,128);
    tbl[17] = v(1,0,0,0,0,0,    1, 4,4,1, 1,0,1, 1,64,128);
    tbl[18] = v(0,1,1,0,0,500,  1, 4,4,1, 1,0,1, 2,64,128);
    tbl[19] = v(1,1,0,0,0,60,   1, 5,4,1, 0,1,1, 2,60,128);
    tbl[20] = v(0,1,0,0,0,7,    0, 5,4,1, 0,1,1, 2,60,128);

    idle_inputs();
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_state("reset");

    // Directed table: fill, overflow discard, drain, error drop, 1-cycle frame
    for (int i = 0; i < 21; i++) begin
      step(tbl[i].sof, tbl[i].eof, tbl[i].err, tbl[i].d1, tbl[i].d0, tbl[i].len);
      chk($sformatf("v%0d wr_en", i), int'(last_en), int'(tbl[i].exp_en));
      chk($sformatf("v%0d wr_ptr", i), int'(bus.wr_ptr_tribit), tbl[i].wr);
      chk($sformatf("v%0d rd_ptr_1", i), int'(bus.rd_ptr_tribit_1), tbl[i].r1);
      chk($sformatf("v%0d rd_ptr_0", i), int'(bus.rd_ptr_tribit_0), tbl[i].r0);
      chk($sformatf("v%0d wr_gf", i), int'(bus.wr_greenflag), int'(tbl[i].wgf));
      chk($sformatf("v%0d rd_gf_1", i), int'(bus.rd_greenflag_1), int'(tbl[i].g1));
      chk($sformatf("v%0d rd_gf_0", i), int'(bus.rd_greenflag_0), int'(tbl[i].g0));
      chk($sformatf("v%0d drop", i), int'(bus.drop_cnt), tbl[i].drop);
      chk($sformatf("v%0d rd_len_1", i), int'(bus.rd_len_1), tbl[i].l1);
      chk($sformatf("v%0d rd_len_0", i), int'(bus.rd_len_0), tbl[i].l0);
    end

    // Randomized traffic with slow, medium and fast readers
    for (int p = 0; p < 3; p++) begin
      int thr1, thr0;
      thr1 = (p == 0) ? 25 : (p == 1) ? 8  : 60;
      thr0 = (p == 0) ? 20 : (p == 1) ? 12 : 55;
      for (int c = 0; c < 500; c++) begin
        step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 35,
             $urandom_range(0, 99) < 15,
             $urandom_range(0, 99) < thr1, $urandom_range(0, 99) < thr0,
             int'($urandom_range(0, 2047)));
      end
    end

    // Mid-frame reset: in-flight frame lost, stray eof afterwards ignored
    step(1, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    idle_inputs();
    #1;
    model_reset();
    chk_reset_state("midrst");
    @(negedge clk);
    rst = 1'b0;
    step(0, 1, 0, 0, 0, 33);
    chk("stray eof wr_en", int'(last_en), 0);
    chk("stray eof wr_ptr", int'(bus.wr_ptr_tribit), 0);
    chk("stray eof drop", int'(bus.drop_cnt), 0);

    // Nine single-cycle frames with both readers consuming alongside commits
    for (int i = 0; i < 9; i++)
      step(1, 1, 0, i > 0, i > 0, 100 + 10 * i);
    chk("wrap wr_ptr", int'(bus.wr_ptr_tribit), 1);
    chk("wrap rd_ptr_1", int'(bus.rd_ptr_tribit_1), 0);
    chk("wrap rd_ptr_0", int'(bus.rd_ptr_tribit_0), 0);
    chk("wrap rd_len_1", int'(bus.rd_len_1), 180);
    chk("wrap wr_gf", int'(bus.wr_greenflag), 1);
    step(0, 0, 0, 0, 0, 0);

    idle_inputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
